// File: rtl/detect_event_logger.sv
// detect_event_logger
//   Timestamps every detection from a Moore sequence detector with a
//   free-running cycle counter. The timestamps are held in a small show-ahead
//   FIFO that is drained over a valid/ready interface. The block also keeps a
//   saturating count of all events and a sticky overflow flag.
//
// Optional feature macro: DETECT_LOG_EDGE_ONLY_EN
//   If this macro is defined, an event is a rising edge of detector_in, so a
//   run of high cycles counts as one event. If it is not defined, every high
//   cycle is an event.
//
// Parameters
//   TS_W   timestamp / free-running counter width
//   DEPTH  FIFO entries (power of two, >= 2)
//   CNT_W  event counter width
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   detector_in  in   detector output, sampled every rising edge
//   clear        in   synchronous clear of FIFO, counters and flag
//   ts_ready     in   consumer accepts the head entry
//   ts_valid     out  FIFO not empty
//   ts_data      out  head timestamp (zero while empty)
//   event_count  out  saturating total event count
//   fifo_level   out  occupancy, 0..DEPTH
//   overflow     out  sticky: an event was dropped because the FIFO was full
module detect_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       detector_in,
  input  logic                       clear,
  input  logic                       ts_ready,
  output logic                       ts_valid,
  output logic [TS_W-1:0]            ts_data,
  output logic [CNT_W-1:0]           event_count,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [TS_W-1:0]  ts_cnt_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic [TS_W-1:0]  mem [DEPTH];

  logic event_hit;
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push;
  logic drop;

`ifdef DETECT_LOG_EDGE_ONLY_EN
  logic prev_reg;

  // The previous sample keeps tracking during clear. This stops a run that
  // spans a clear from being seen as a fresh rising edge afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_reg <= 1'b0;
    end else begin
      prev_reg <= detector_in;
    end
  end

  assign event_hit = detector_in & ~prev_reg;
`else
  assign event_hit = detector_in;
`endif

  assign fifo_full  = (level_reg == LW'(DEPTH));
  assign fifo_empty = (level_reg == '0);

  // A push into a full FIFO is accepted when a pop happens in the same cycle.
  // The slot being written is the one the head is leaving.
  assign pop  = ~fifo_empty & ts_ready;
  assign push = event_hit & (~fifo_full | pop);
  assign drop = event_hit & fifo_full & ~pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts_cnt_reg   <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (clear) begin
      ts_cnt_reg   <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      ts_cnt_reg <= ts_cnt_reg + TS_W'(1);
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push && !pop) begin
        level_reg <= level_reg + LW'(1);
      end else if (pop && !push) begin
        level_reg <= level_reg - LW'(1);
      end
      if (event_hit && (count_reg != {CNT_W{1'b1}})) begin
        count_reg <= count_reg + CNT_W'(1);
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Storage has no reset. Entries are only visible through level_reg, so
  // stale contents after a reset or clear are never exposed.
  always_ff @(posedge clock) begin
    if (!clear && push) begin
      mem[wr_ptr_reg] <= ts_cnt_reg;
    end
  end

  assign ts_valid    = ~fifo_empty;
  assign ts_data     = fifo_empty ? '0 : mem[rd_ptr_reg];
  assign event_count = count_reg;
  assign fifo_level  = level_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_detect_event_logger.sv
// Directed testbench for detect_event_logger. It uses one instance with the
// default parameters and one small instance (TS_W=4, CNT_W=4) for the
// saturation and wrap scenario.
module tb_detect_event_logger;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        detector_in = 1'b0;
  logic        clear = 1'b0;
  logic        ts_ready = 1'b0;
  logic        ts_valid;
  logic [15:0] ts_data;
  logic [15:0] event_count;
  logic [3:0]  fifo_level;
  logic        overflow;

  logic        det2 = 1'b0;
  logic        clr2 = 1'b0;
  logic        rdy2 = 1'b0;
  logic        v2;
  logic [3:0]  d2;
  logic [3:0]  c2;
  logic [3:0]  l2;
  logic        o2;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  detect_event_logger #(.TS_W(16), .DEPTH(8), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .detector_in(detector_in), .clear(clear),
    .ts_ready(ts_ready), .ts_valid(ts_valid), .ts_data(ts_data),
    .event_count(event_count), .fifo_level(fifo_level), .overflow(overflow)
  );

  detect_event_logger #(.TS_W(4), .DEPTH(8), .CNT_W(4)) dut_small (
    .clock(clock), .reset(reset), .detector_in(det2), .clear(clr2),
    .ts_ready(rdy2), .ts_valid(v2), .ts_data(d2),
    .event_count(c2), .fifo_level(l2), .overflow(o2)
  );

  // Drive the inputs for one edge, then sample 1 time unit after that edge.
  task automatic step(input logic d, input logic r, input logic c);
    detector_in = d;
    ts_ready    = r;
    clear       = c;
    @(posedge clock);
    #1;
    detector_in = 1'b0;
    ts_ready    = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic step2(input logic d, input logic r, input logic c);
    det2 = d;
    rdy2 = r;
    clr2 = c;
    @(posedge clock);
    #1;
    det2 = 1'b0;
    rdy2 = 1'b0;
    clr2 = 1'b0;
  endtask

  // Reset is released 1 unit after an edge, so the next edge is edge 0.
  task automatic test_reset;
    reset       = 1'b0;
    detector_in = 1'b1;
    @(posedge clock);
    #1;
    detector_in = 1'b0;
    checks++; if (ts_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", ts_valid); end
    checks++; if (ts_data !== 16'd0) begin fails++; $display("FAIL reset_data got=%0d exp=0", ts_data); end
    checks++; if (event_count !== 16'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", event_count); end
    checks++; if (fifo_level !== 4'd0) begin fails++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    reset = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single;
    test_reset();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);  // edge 5
    checks++; if (ts_valid !== 1'b1) begin fails++; $display("FAIL single_valid got=%b exp=1", ts_valid); end
    checks++; if (ts_data !== 16'd5) begin fails++; $display("FAIL single_data got=%0d exp=5", ts_data); end
    checks++; if (event_count !== 16'd1) begin fails++; $display("FAIL single_count got=%0d exp=1", event_count); end
    checks++; if (fifo_level !== 4'd1) begin fails++; $display("FAIL single_level got=%0d exp=1", fifo_level); end
    step(1'b0, 1'b1, 1'b0);
    checks++; if (ts_valid !== 1'b0) begin fails++; $display("FAIL single_pop_valid got=%b exp=0", ts_valid); end
    checks++; if (fifo_level !== 4'd0) begin fails++; $display("FAIL single_pop_level got=%0d exp=0", fifo_level); end
    // A ready with an empty FIFO must not change anything.
    step(1'b0, 1'b1, 1'b0);
    checks++; if (fifo_level !== 4'd0) begin fails++; $display("FAIL empty_pop_level got=%0d exp=0", fifo_level); end
    $display("test_single done");
  endtask

  task automatic test_overflow;
    test_reset();
    for (int k = 0; k <= 20; k++) step((k % 2 == 0) && (k >= 2), 1'b0, 1'b0);
    checks++; if (fifo_level !== 4'd8) begin fails++; $display("FAIL ovf_level got=%0d exp=8", fifo_level); end
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (event_count !== 16'd10) begin fails++; $display("FAIL ovf_count got=%0d exp=10", event_count); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ts_valid !== 1'b1 || ts_data !== 16'(2 * (i + 1))) begin
        fails++; $display("FAIL ovf_drain%0d got=%0d/%b exp=%0d/1", i, ts_data, ts_valid, 2 * (i + 1));
      end
      step(1'b0, 1'b1, 1'b0);
    end
    checks++; if (ts_valid !== 1'b0) begin fails++; $display("FAIL ovf_drained_valid got=%b exp=0", ts_valid); end
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    step(1'b0, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    checks++; if (event_count !== 16'd0) begin fails++; $display("FAIL ovf_clear_count got=%0d exp=0", event_count); end
    $display("test_overflow done");
  endtask

  task automatic test_full_push_pop;
    test_reset();
    for (int k = 0; k < 16; k++) step(k % 2 == 0, 1'b0, 1'b0);  // events 0,2,..,14
    checks++; if (fifo_level !== 4'd8) begin fails++; $display("FAIL full_level got=%0d exp=8", fifo_level); end
    step(1'b1, 1'b1, 1'b0);  // edge 16: push and pop together
    checks++; if (fifo_level !== 4'd8) begin fails++; $display("FAIL fpp_level got=%0d exp=8", fifo_level); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL fpp_ovf got=%b exp=0", overflow); end
    checks++; if (event_count !== 16'd9) begin fails++; $display("FAIL fpp_count got=%0d exp=9", event_count); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ts_data !== 16'(2 * (i + 1))) begin
        fails++; $display("FAIL fpp_drain%0d got=%0d exp=%0d", i, ts_data, 2 * (i + 1));
      end
      step(1'b0, 1'b1, 1'b0);
    end
    checks++; if (fifo_level !== 4'd0) begin fails++; $display("FAIL fpp_empty got=%0d exp=0", fifo_level); end
    $display("test_full_push_pop done");
  endtask

  task automatic test_high_run;
    test_reset();
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0);  // edges 10..13
    step(1'b0, 1'b0, 1'b0);
`ifdef DETECT_LOG_EDGE_ONLY_EN
    checks++; if (fifo_level !== 4'd1) begin fails++; $display("FAIL run_level got=%0d exp=1", fifo_level); end
    checks++; if (event_count !== 16'd1) begin fails++; $display("FAIL run_count got=%0d exp=1", event_count); end
    checks++; if (ts_data !== 16'd10) begin fails++; $display("FAIL run_data got=%0d exp=10", ts_data); end
`else
    checks++; if (fifo_level !== 4'd4) begin fails++; $display("FAIL run_level got=%0d exp=4", fifo_level); end
    checks++; if (event_count !== 16'd4) begin fails++; $display("FAIL run_count got=%0d exp=4", event_count); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ts_data !== 16'(10 + i)) begin fails++; $display("FAIL run_drain%0d got=%0d exp=%0d", i, ts_data, 10 + i); end
      step(1'b0, 1'b1, 1'b0);
    end
`endif
    $display("test_high_run done");
  endtask

  task automatic test_clear;
    test_reset();
    for (int k = 0; k < 6; k++) step(k % 2 == 1, 1'b0, 1'b0);  // events 1,3,5
    checks++; if (fifo_level !== 4'd3) begin fails++; $display("FAIL clr_pre_level got=%0d exp=3", fifo_level); end
    step(1'b1, 1'b0, 1'b1);  // event in the clear cycle is discarded
    checks++; if (fifo_level !== 4'd0) begin fails++; $display("FAIL clr_level got=%0d exp=0", fifo_level); end
    checks++; if (event_count !== 16'd0) begin fails++; $display("FAIL clr_count got=%0d exp=0", event_count); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL clr_ovf got=%b exp=0", overflow); end
    checks++; if (ts_valid !== 1'b0) begin fails++; $display("FAIL clr_valid got=%b exp=0", ts_valid); end
    step(1'b0, 1'b0, 1'b0);  // counter reads 0 here
    step(1'b1, 1'b0, 1'b0);  // counter reads 1 here
    checks++; if (ts_data !== 16'd1) begin fails++; $display("FAIL clr_restart got=%0d exp=1", ts_data); end
    $display("test_clear done");
  endtask

  task automatic test_async_reset;
    test_reset();
    step(1'b1, 1'b0, 1'b0);  // edge 0
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);  // edge 2
    checks++; if (ts_data !== 16'd0) begin fails++; $display("FAIL ar_head got=%0d exp=0", ts_data); end
    step(1'b0, 1'b1, 1'b0);
    checks++; if (ts_data !== 16'd2) begin fails++; $display("FAIL ar_head2 got=%0d exp=2", ts_data); end
    #1 reset = 1'b0;  // between edges
    #1;
    checks++; if (ts_valid !== 1'b0) begin fails++; $display("FAIL ar_valid got=%b exp=0", ts_valid); end
    checks++; if (fifo_level !== 4'd0) begin fails++; $display("FAIL ar_level got=%0d exp=0", fifo_level); end
    checks++; if (event_count !== 16'd0) begin fails++; $display("FAIL ar_count got=%0d exp=0", event_count); end
    @(posedge clock);
    #1 reset = 1'b1;
    $display("test_async_reset done");
  endtask

  task automatic test_saturation;
    step2(1'b0, 1'b0, 1'b1);
`ifdef DETECT_LOG_EDGE_ONLY_EN
    for (int j = 0; j < 40; j++) begin
      step2(j % 2 == 0, 1'b1, 1'b0);
      if (j % 2 == 0) begin
        checks++;
        if (v2 !== 1'b1 || d2 !== 4'(j % 16) || c2 !== 4'((j / 2 + 1 > 15) ? 15 : j / 2 + 1)) begin
          fails++; $display("FAIL sat_e%0d got=%0d/%0d/%b", j, d2, c2, v2);
        end
      end else begin
        checks++; if (v2 !== 1'b0) begin fails++; $display("FAIL sat_o%0d valid got=%b exp=0", j, v2); end
      end
    end
`else
    for (int j = 0; j < 20; j++) begin
      step2(1'b1, 1'b1, 1'b0);
      checks++;
      if (v2 !== 1'b1 || d2 !== 4'(j % 16) || c2 !== 4'((j + 1 > 15) ? 15 : j + 1) || l2 !== 4'd1) begin
        fails++; $display("FAIL sat_%0d got=%0d/%0d/%b/%0d exp=%0d/%0d/1/1", j, d2, c2, v2, l2,
                          j % 16, (j + 1 > 15) ? 15 : j + 1);
      end
    end
`endif
    checks++; if (o2 !== 1'b0) begin fails++; $display("FAIL sat_ovf got=%b exp=0", o2); end
    $display("test_saturation done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_high_run();
    test_clear();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
